// File: rtl/vram_write_ctrl_pkg.sv
// Shared VGA buffer constants: geometry, bus register map, STATUS bit layout
// and the bus request bundle used by the write controller.
package vram_write_ctrl_pkg;

  localparam int VRAM_DEPTH  = 4800;
  localparam int VRAM_ADDR_W = 13;

  localparam logic [2:0] REG_ADDR_LO = 3'd0;
  localparam logic [2:0] REG_ADDR_HI = 3'd1;
  localparam logic [2:0] REG_DATA    = 3'd2;
  localparam logic [2:0] REG_STRIDE  = 3'd3;
  localparam logic [2:0] REG_CNT_LO  = 3'd4;
  localparam logic [2:0] REG_CNT_HI  = 3'd5;
  localparam logic [2:0] REG_FILL_GO = 3'd6;
  localparam logic [2:0] REG_STATUS  = 3'd7;

  localparam int ST_BUSY    = 0;
  localparam int ST_OVERRUN = 1;
  localparam int ST_RANGE   = 2;

  typedef struct packed {
    logic       we;
    logic       re;
    logic [2:0] sel;
    logic [7:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/vram_addr_step.sv
// Wrapping pointer adder: next = ptr + max(stride,1), folded back into 0..DEPTH-1.
module vram_addr_step
  import vram_write_ctrl_pkg::*;
#(
  parameter int DEPTH  = VRAM_DEPTH,
  parameter int ADDR_W = VRAM_ADDR_W
) (
  input  logic [ADDR_W-1:0] ptr,
  input  logic [7:0]        stride,
  output logic [ADDR_W-1:0] next
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  logic [7:0]      step;
  logic [ADDR_W:0] sum;

  assign step = (stride == 8'd0) ? 8'd1 : stride;
  // One extra bit so ptr+step never overflows before the wrap compare.
  assign sum  = {1'b0, ptr} + {{(ADDR_W-7){1'b0}}, step};
  assign next = (sum >= DEPTH_W) ? ADDR_W'(sum - DEPTH_W) : sum[ADDR_W-1:0];

endmodule

// File: rtl/vram_write_ctrl.sv
// CPU-side write controller for the VGA buffer: register window, auto-increment
// data port, fill engine, and arbitration of the single buffer write port.
module vram_write_ctrl
  import vram_write_ctrl_pkg::*;
#(
  parameter int DEPTH  = VRAM_DEPTH,
  parameter int ADDR_W = VRAM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        bus_sel,
  input  logic [7:0]        bus_wdata,
  input  logic              bus_we,
  input  logic              bus_re,
  output logic [7:0]        bus_rdata,
  output logic              busy,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_w_addr,
  output logic [7:0]        mem_w_data
);

  localparam int              HI_W    = ADDR_W - 8;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  typedef enum logic {IDLE, FILL} state_t;

  state_t          state, state_nxt;
  bus_req_t        req;
  logic [ADDR_W-1:0] ptr, ptr_step;
  logic [7:0]      stride, fill_byte, rd_mux;
  logic [15:0]     cnt, rem;
  logic            ovr_flag, rng_flag;
  logic            ptr_oob, stat_rd;
  logic            data_wr, data_oob, fill_go, fill_wr, cfg_wr, ovr_set, rng_set;

  assign req     = '{we: bus_we, re: bus_re, sel: bus_sel, wdata: bus_wdata};
  assign ptr_oob = {1'b0, ptr} >= DEPTH_W;
  assign stat_rd = req.re && (req.sel == REG_STATUS);
  assign busy    = (state == FILL);

  vram_addr_step #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_step (
    .ptr    (ptr),
    .stride (stride),
    .next   (ptr_step)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    data_wr   = 1'b0;
    data_oob  = 1'b0;
    fill_go   = 1'b0;
    fill_wr   = 1'b0;
    cfg_wr    = 1'b0;
    ovr_set   = 1'b0;
    rng_set   = 1'b0;
    case (state)
      IDLE: begin
        if (req.we) begin
          case (req.sel)
            REG_DATA: begin
              data_oob = ptr_oob;
              rng_set  = ptr_oob;
              data_wr  = !ptr_oob;
            end
            REG_FILL_GO: begin
              if (ptr_oob) rng_set = 1'b1;
              else if (cnt != 16'd0) begin
                fill_go   = 1'b1;
                state_nxt = FILL;
              end
            end
            default: cfg_wr = 1'b1;
          endcase
        end
      end
      FILL: begin
        // The first fill write was issued on the FILL_GO edge, so rem counts the rest.
        if (rem != 16'd0) fill_wr = 1'b1;
        else              state_nxt = IDLE;
        if (req.we && req.sel != REG_STATUS) ovr_set = 1'b1;
      end
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (req.sel)
      REG_ADDR_LO: rd_mux = ptr[7:0];
      REG_ADDR_HI: rd_mux = 8'(ptr >> 8);
      REG_STRIDE:  rd_mux = stride;
      REG_CNT_LO:  rd_mux = cnt[7:0];
      REG_CNT_HI:  rd_mux = cnt[15:8];
      REG_STATUS: begin
        rd_mux[ST_BUSY]    = busy;
        rd_mux[ST_OVERRUN] = ovr_flag;
        rd_mux[ST_RANGE]   = rng_flag;
      end
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr        <= '0;
      stride     <= 8'd1;
      cnt        <= '0;
      rem        <= '0;
      fill_byte  <= '0;
      ovr_flag   <= 1'b0;
      rng_flag   <= 1'b0;
      bus_rdata  <= '0;
      mem_w_en   <= 1'b0;
      mem_w_addr <= '0;
      mem_w_data <= '0;
    end else begin
      mem_w_en <= 1'b0;
      if (data_wr || fill_go || fill_wr) begin
        mem_w_en   <= 1'b1;
        mem_w_addr <= ptr;
        mem_w_data <= fill_wr ? fill_byte : req.wdata;
        ptr        <= ptr_step;
      end
      if (data_oob) ptr <= '0;

      if (fill_go) begin
        fill_byte <= req.wdata;
        rem       <= cnt - 16'd1;
      end else if (fill_wr) begin
        rem <= rem - 16'd1;
      end

      if (cfg_wr) begin
        case (req.sel)
          REG_ADDR_LO: ptr[7:0]        <= req.wdata;
          REG_ADDR_HI: ptr[ADDR_W-1:8] <= req.wdata[HI_W-1:0];
          REG_STRIDE:  stride          <= req.wdata;
          REG_CNT_LO:  cnt[7:0]        <= req.wdata;
          REG_CNT_HI:  cnt[15:8]       <= req.wdata;
          default: ;
        endcase
      end

      if (req.re) bus_rdata <= rd_mux;

      // A set in the same cycle as a STATUS read must survive the clear.
      if (ovr_set)      ovr_flag <= 1'b1;
      else if (stat_rd) ovr_flag <= 1'b0;
      if (rng_set)      rng_flag <= 1'b1;
      else if (stat_rd) rng_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vram_write_ctrl.sv
// Scoreboard bench for vram_write_ctrl: expected buffer writes are queued with
// their due cycle when stimulus is driven, and matched as the DUT issues them.
module tb_vram_write_ctrl;
  import vram_write_ctrl_pkg::*;

  localparam int D = 4800;

  logic        clk, rst_n;
  logic [2:0]  bus_sel;
  logic [7:0]  bus_wdata, bus_rdata, mem_w_data;
  logic        bus_we, bus_re, busy, mem_w_en;
  logic [12:0] mem_w_addr;

  vram_write_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_sel    (bus_sel),
    .bus_wdata  (bus_wdata),
    .bus_we     (bus_we),
    .bus_re     (bus_re),
    .bus_rdata  (bus_rdata),
    .busy       (busy),
    .mem_w_en   (mem_w_en),
    .mem_w_addr (mem_w_addr),
    .mem_w_data (mem_w_data)
  );

  typedef struct {int cyc; int addr; int data;} exp_t;
  exp_t sbq[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int busy_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: each due entry must appear on exactly its cycle; anything else is spurious.
  always @(negedge clk) begin
    exp_t e;
    if (busy) busy_cnt++;
    if (sbq.size() != 0 && sbq[0].cyc == cyc) begin
      e = sbq.pop_front();
      chk("wr_en",   int'(mem_w_en),   1);
      chk("wr_addr", int'(mem_w_addr), e.addr);
      chk("wr_data", int'(mem_w_data), e.data);
    end else if (mem_w_en) begin
      chk("wr_spurious", int'(mem_w_en), 0);
    end
  end

  // All bus tasks are entered on a negedge and return on the following negedge.
  task automatic bus_wr(input logic [2:0] sel, input logic [7:0] d);
    bus_we = 1'b1; bus_sel = sel; bus_wdata = d;
    @(negedge clk);
    bus_we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] sel, input string tag, input int exp);
    bus_re = 1'b1; bus_sel = sel;
    @(negedge clk);
    bus_re = 1'b0;
    chk(tag, int'(bus_rdata), exp);
  endtask

  task automatic data_wr(input logic [7:0] d, input int addr);
    sbq.push_back('{cyc: cyc + 1, addr: addr, data: int'(d)});
    bus_wr(REG_DATA, d);
  endtask

  task automatic fill(input logic [7:0] b, input int start, input int strd, input int npush);
    int c;
    c = cyc;
    for (int k = 0; k < npush; k++)
      sbq.push_back('{cyc: c + 1 + k, addr: (start + k * strd) % D, data: int'(b)});
    bus_wr(REG_FILL_GO, b);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && busy; i++) @(negedge clk);
    if (busy) chk("idle_timeout", int'(busy), 0);
  endtask

  initial begin
    rst_n = 1'b0; bus_we = 1'b0; bus_re = 1'b0; bus_sel = '0; bus_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_en",    int'(mem_w_en),   0);
    chk("rst_addr",  int'(mem_w_addr), 0);
    chk("rst_data",  int'(mem_w_data), 0);
    chk("rst_busy",  int'(busy),       0);
    chk("rst_rdata", int'(bus_rdata),  0);
    rst_n = 1'b1;
    @(negedge clk);
    rd(REG_STRIDE,  "rst_stride", 1);
    rd(REG_ADDR_LO, "rst_ptr",    0);
    rd(REG_CNT_LO,  "rst_cnt",    0);

    // Auto-increment data port
    bus_wr(REG_ADDR_LO, 8'h10);
    bus_wr(REG_ADDR_HI, 8'h00);
    data_wr(8'h41, 'h010);
    data_wr(8'h42, 'h011);
    rd(REG_ADDR_LO, "ptr_after_data", 'h12);
    chk("hold_en",   int'(mem_w_en),   0);
    chk("hold_addr", int'(mem_w_addr), 'h011);
    chk("hold_data", int'(mem_w_data), 'h42);

    // Wrap at the end of the buffer
    bus_wr(REG_ADDR_HI, 8'h12);
    bus_wr(REG_ADDR_LO, 8'hBF);
    data_wr(8'h55, 4799);
    rd(REG_ADDR_LO, "wrap1_lo", 0);
    rd(REG_ADDR_HI, "wrap1_hi", 0);
    bus_wr(REG_STRIDE, 8'd3);
    bus_wr(REG_ADDR_HI, 8'h12);
    bus_wr(REG_ADDR_LO, 8'hBE);
    data_wr(8'h56, 4798);
    rd(REG_ADDR_LO, "wrap3_lo", 1);

    // Stride 0 reads back as 0 but steps by 1
    bus_wr(REG_STRIDE, 8'd0);
    rd(REG_STRIDE, "stride0_rd", 0);
    data_wr(8'h57, 1);
    rd(REG_ADDR_LO, "stride0_ptr", 2);

    // Strided fill
    bus_wr(REG_ADDR_LO, 8'h64);
    bus_wr(REG_ADDR_HI, 8'h00);
    bus_wr(REG_STRIDE,  8'd80);
    bus_wr(REG_CNT_LO,  8'd5);
    bus_wr(REG_CNT_HI,  8'd0);
    busy_cnt = 0;
    fill(8'h20, 100, 80, 5);
    wait_idle();
    chk("fill_busy_cycles", busy_cnt, 5);
    rd(REG_ADDR_LO, "fill_ptr_lo", 'hF4);
    rd(REG_ADDR_HI, "fill_ptr_hi", 'h01);
    rd(REG_CNT_LO,  "fill_cnt_kept", 5);

    // Contention: DATA write during a fill is dropped and flags overrun
    busy_cnt = 0;
    fill(8'h21, 500, 80, 5);
    bus_wr(REG_DATA, 8'h99);
    rd(REG_STATUS, "stat_busy_ovr", 'h03);
    wait_idle();
    chk("fill2_busy_cycles", busy_cnt, 5);
    rd(REG_STATUS, "stat_cleared", 'h00);
    rd(REG_ADDR_LO, "fill2_ptr_lo", 'h84);
    rd(REG_ADDR_HI, "fill2_ptr_hi", 'h03);

    // Out-of-range pointer and empty fill
    bus_wr(REG_ADDR_HI, 8'hFF);
    rd(REG_ADDR_HI, "addr_hi_mask", 'h1F);
    bus_wr(REG_ADDR_LO, 8'hFF);
    bus_wr(REG_DATA, 8'h77);
    rd(REG_ADDR_LO, "oob_ptr_lo", 0);
    rd(REG_ADDR_HI, "oob_ptr_hi", 0);
    rd(REG_STATUS, "stat_range", 'h04);
    rd(REG_STATUS, "stat_range_clr", 'h00);
    bus_wr(REG_CNT_LO, 8'd0);
    busy_cnt = 0;
    bus_wr(REG_FILL_GO, 8'h11);
    repeat (5) @(negedge clk);
    chk("cnt0_no_busy", busy_cnt, 0);

    // Reset in the middle of a long fill
    bus_wr(REG_STRIDE,  8'd1);
    bus_wr(REG_ADDR_LO, 8'd0);
    bus_wr(REG_ADDR_HI, 8'd0);
    bus_wr(REG_CNT_HI,  8'h03);
    bus_wr(REG_CNT_LO,  8'hE8);
    fill(8'h33, 0, 1, 10);
    repeat (9) @(negedge clk);
    chk("mid_w10_en",   int'(mem_w_en),   1);
    chk("mid_w10_addr", int'(mem_w_addr), 9);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_en",   int'(mem_w_en),   0);
    chk("mid_rst_busy", int'(busy),       0);
    chk("mid_rst_addr", int'(mem_w_addr), 0);
    chk("mid_rst_data", int'(mem_w_data), 0);
    rst_n = 1'b1;
    @(negedge clk);
    rd(REG_STRIDE,  "mid_stride", 1);
    rd(REG_CNT_HI,  "mid_cnt_hi", 0);
    rd(REG_ADDR_LO, "mid_ptr",    0);
    repeat (20) @(negedge clk);
    chk("mid_busy_after", int'(busy), 0);
    chk("sb_empty", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_write_ctrl.md
Name: vram_write_ctrl

Overview:
- CPU-side controller for the VGA frame/text buffer write port.
- Exposes an 8-register bus window: address pointer, data port with auto-increment, programmable stride, hardware fill engine, status.
- Arbitrates the single memory write port between direct CPU data writes and the fill engine; drives w_en/w_addr/w_data of the dual-port buffer.
- Sits between the JML-8 bus decode and the buffer, in the buffer's write-clock domain.

Parameters:
- DEPTH, 4800, number of bytes in the buffer; valid addresses are 0..DEPTH-1.
- ADDR_W, 13, address width; must satisfy 2^ADDR_W >= DEPTH, ADDR_W > 8.

Ports:
- clk  in  1  write-side clock.
- rst_n  in  1  synchronous, active-low reset.
- bus_sel  in  3  register select.
- bus_wdata  in  8  bus write data.
- bus_we  in  1  write strobe, one cycle per access.
- bus_re  in  1  read strobe, one cycle per access.
- bus_rdata  out  8  read data, registered.
- busy  out  1  fill in progress.
- mem_w_en  out  1  buffer write enable.
- mem_w_addr  out  ADDR_W  buffer write address.
- mem_w_data  out  8  buffer write data.

Behaviour:
- Register map (bus_sel):
  - 0 ADDR_LO, RW.
  - 1 ADDR_HI, RW; low ADDR_W-8 bits used, upper bits read 0.
  - 2 DATA, W; reads return 0.
  - 3 STRIDE, RW; 0 is treated as 1 when stepping, but reads back as written.
  - 4 CNT_LO, RW.
  - 5 CNT_HI, RW.
  - 6 FILL_GO, W: start a fill using bus_wdata as the fill byte; reads return 0.
  - 7 STATUS, R: bit0 busy, bit1 overrun (sticky), bit2 range (sticky), others 0. Reading clears bits 1–2.
- Reset (rst_n=0 at a clk edge):
  - ptr=0, STRIDE=1, CNT=0, state IDLE.
  - Sticky flags 0.
  - bus_rdata=0, busy=0, mem_w_en=0, mem_w_addr=0, mem_w_data=0.
  - Reset mid-fill aborts the fill immediately; no further writes are issued.
- Step function: next = ptr+step, computed ADDR_W+1 bits wide; if next >= DEPTH, next -= DEPTH.
- Bus reads: bus_re in cycle N sets bus_rdata in N+1. bus_rdata holds its value otherwise.
- DATA write in IDLE, bus_we at N:
  - In N+1: mem_w_en=1, mem_w_addr=ptr, mem_w_data=bus_wdata, and ptr=step(ptr).
  - mem_w_en is a single-cycle pulse.
- Out-of-range pointer: if ptr >= DEPTH at a DATA write, the memory write is suppressed, ptr becomes 0 and range is set.
- Fill start: FILL_GO at N with CNT=0 or ptr >= DEPTH is a no-op; ptr>=DEPTH also sets range. Otherwise:
  - FSM enters FILL in N+1; busy=1 from N+1.
  - One mem write per cycle at ptr with the fill byte, ptr stepping each cycle.
  - Exactly CNT writes occur (N+1..N+CNT).
  - busy falls in N+CNT+1; state returns to IDLE.
- After a fill: ptr = start + CNT*stride mod DEPTH. CNT is not modified.
- During FILL, bus writes to DATA, ADDR_*, STRIDE, CNT_* or FILL_GO are dropped and set overrun. Reads remain serviced.
- Same-cycle set and clear of a sticky flag: set wins.
- bus_we and bus_re in the same cycle: both are honoured.
- mem_w_addr and mem_w_data hold their last values when mem_w_en=0.

Decomposition:
- DEPTH, ADDR_W and the register offset constants (REG_ADDR_LO..REG_STATUS) and the STATUS bit positions live in the shared VGA specs include.
- FSM state encoding (IDLE, FILL) is local.
- Sub-module vram_addr_step: combinational wrap adder (ptr, stride → next); reused by the DATA and FILL paths.

Test Plan:
- Reset, then write ADDR_LO=0x10, ADDR_HI=0, then DATA=0x41, DATA=0x42 → writes (0x010,0x41) and (0x011,0x42), each one cycle after its strobe; ptr reads back 0x12.
- Wrap: ptr=4799, STRIDE=1, DATA=0x55 → write at 4799; ptr=0. With STRIDE=3 and ptr=4798 → next ptr=1.
- Fill: ptr=100, STRIDE=80, CNT=5, FILL_GO=0x20 → 5 consecutive writes of 0x20 at 100,180,260,340,420; busy high exactly 5 cycles; ptr=500.
- Contention: DATA write issued during the busy cycles of the previous fill → no extra mem write; STATUS reads 0x03, the next read returns 0x00 after busy drops.
- Range/no-op: ADDR_HI/LO set to 0x1FFF, DATA write → no mem_w_en, ptr=0, STATUS bit2 set. FILL_GO with CNT=0 → busy never asserts.
- Reset mid-fill: CNT=1000, assert rst_n=0 at the 10th write → mem_w_en=0 next cycle; busy=0; registers are at their reset values.
